// File: rtl/nonce_ctrl_pkg.sv
//------------------------------------------------------------------------------
// nonce_ctrl_pkg -- shared state/status encodings for the nonce search controller. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package nonce_ctrl_pkg;

  localparam int DEF_PARTITIONBITS = 4;
  localparam int ROUNDBITS         = 32 - DEF_PARTITIONBITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FOUND     = 2'd0,
    EXHAUSTED = 2'd1,
    ABORTED   = 2'd2
  } status_t;

endpackage

`default_nettype wire

// File: rtl/nonce_search_ctrl_inflight.sv
//------------------------------------------------------------------------------
// inflight_tracker -- counts issued-but-unretired rounds, exposes next-cycle flags. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module inflight_tracker #(
  parameter int MAX_INFLIGHT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full_next,
  output logic empty_next
);

  localparam int                C_CW   = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [C_CW-1:0]   C_FULL = C_CW'(MAX_INFLIGHT);

  logic [C_CW-1:0] r_count;
  logic [C_CW-1:0] w_count_next;
  logic            w_dec_ok;

  // Retires with nothing outstanding (e.g. stale responses after reset) are dropped.
  assign w_dec_ok = dec && (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    if (inc && !w_dec_ok)
      w_count_next = r_count + 1'b1;
    else if (!inc && w_dec_ok)
      w_count_next = r_count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else
      r_count <= w_count_next;
  end

  assign full_next  = (w_count_next == C_FULL);
  assign empty_next = (w_count_next == '0);

endmodule

`default_nettype wire

// File: rtl/nonce_search_ctrl.sv
//------------------------------------------------------------------------------
// nonce_search_ctrl -- issues rounds for one mining job, drains, reports one result. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nonce_search_ctrl
  import nonce_ctrl_pkg::*;
#(
  parameter int PARTITIONBITS = 4,
  parameter int MAX_INFLIGHT  = 16,
  parameter int JOBIDBITS     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_valid_i,
  output logic                      job_ready_o,
  input  logic [JOBIDBITS-1:0]      job_id_i,
  input  logic [32-PARTITIONBITS-1:0] job_rounds_i,
  input  logic                      abort_i,
  output logic                      proc_valid_o,
  output logic                      proc_newblock_o,
  input  logic                      dec_valid_i,
  input  logic                      dec_success_i,
  input  logic [31:0]               dec_nonce_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [1:0]                res_status_o,
  output logic [31:0]               res_nonce_o,
  output logic [JOBIDBITS-1:0]      res_job_id_o,
  output logic                      busy_o
);

  localparam int C_ROUND_W = 32 - PARTITIONBITS;
  localparam int C_COUNT_W = C_ROUND_W + 1;

  state_t                 r_state;
  status_t                r_status;
  logic [JOBIDBITS-1:0]   r_job_id;
  logic [C_COUNT_W-1:0]   r_limit;
  logic [C_COUNT_W-1:0]   r_issued;
  logic [31:0]            r_nonce;
  logic                   r_found;
  logic                   r_aborted;
  logic                   r_proc_valid;
  logic                   r_newblock;
  logic                   r_res_valid;
  logic                   r_job_ready;
  logic                   r_busy;

  logic                   w_issue;
  logic                   w_hit;
  logic                   w_full_next;
  logic                   w_empty_next;
  logic [C_COUNT_W-1:0]   w_issued_next;
  status_t                w_status;

  assign w_issue       = r_proc_valid;
  assign w_hit         = dec_valid_i && dec_success_i;
  assign w_issued_next = r_issued + {{(C_COUNT_W-1){1'b0}}, w_issue};

  inflight_tracker #(
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_inflight (
    .clk        (clk),
    .rst_n      (rst),
    .inc        (w_issue),
    .dec        (dec_valid_i),
    .full_next  (w_full_next),
    .empty_next (w_empty_next)
  );

  // Status as it will stand once this cycle's hit/abort are folded in.
  always_comb begin
    w_status = EXHAUSTED;
    if (r_found || w_hit)
      w_status = FOUND;
    else if (r_aborted || abort_i)
      w_status = ABORTED;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_status     <= FOUND;
      r_job_id     <= '0;
      r_limit      <= '0;
      r_issued     <= '0;
      r_nonce      <= '0;
      r_found      <= 1'b0;
      r_aborted    <= 1'b0;
      r_proc_valid <= 1'b0;
      r_newblock   <= 1'b0;
      r_res_valid  <= 1'b0;
      r_job_ready  <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_proc_valid <= 1'b0;
      r_newblock   <= 1'b0;
      r_issued     <= w_issued_next;
      case (r_state)
        IDLE: begin
          if (job_valid_i) begin
            r_job_id     <= job_id_i;
            r_limit      <= (job_rounds_i == '0) ? {1'b1, {C_ROUND_W{1'b0}}}
                                                 : {1'b0, job_rounds_i};
            r_issued     <= '0;
            r_nonce      <= '0;
            r_found      <= 1'b0;
            r_aborted    <= 1'b0;
            r_proc_valid <= 1'b1;
            r_newblock   <= 1'b1;
            r_job_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= RUN;
          end
        end
        RUN: begin
          if (abort_i)
            r_aborted <= 1'b1;
          if (w_hit) begin
            r_found <= 1'b1;
            r_nonce <= dec_nonce_i;
            r_state <= DRAIN;
          end else if (abort_i) begin
            r_state <= DRAIN;
          end else if (w_issue && (w_issued_next == r_limit)) begin
            r_state <= DRAIN;
          end else begin
            r_proc_valid <= !w_full_next;
          end
        end
        DRAIN: begin
          if (abort_i)
            r_aborted <= 1'b1;
          if (w_hit && !r_found) begin
            r_found <= 1'b1;
            r_nonce <= dec_nonce_i;
          end
          if (w_empty_next) begin
            r_status    <= w_status;
            r_res_valid <= 1'b1;
            r_state     <= REPORT;
          end
        end
        REPORT: begin
          if (res_ready_i) begin
            r_res_valid <= 1'b0;
            r_job_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign job_ready_o     = r_job_ready;
  assign proc_valid_o    = r_proc_valid;
  assign proc_newblock_o = r_newblock;
  assign res_valid_o     = r_res_valid;
  assign res_status_o    = r_status;
  assign res_nonce_o     = r_nonce;
  assign res_job_id_o    = r_job_id;
  assign busy_o          = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_nonce_search_ctrl.sv
//------------------------------------------------------------------------------
// tb_nonce_search_ctrl -- directed jobs, decoder model, result scoreboard. Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_nonce_search_ctrl;

  localparam int MAXI = 16;
  localparam int BIG  = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        job_valid_i = 1'b0;
  logic        job_ready_o;
  logic [7:0]  job_id_i = '0;
  logic [27:0] job_rounds_i = '0;
  logic        abort_i = 1'b0;
  logic        proc_valid_o, proc_newblock_o;
  logic        dec_valid_i = 1'b0, dec_success_i = 1'b0;
  logic [31:0] dec_nonce_i = '0;
  logic        res_valid_o;
  logic        res_ready_i = 1'b1;
  logic [1:0]  res_status_o;
  logic [31:0] res_nonce_o;
  logic [7:0]  res_job_id_o;
  logic        busy_o;

  always #5 clk = ~clk;

  nonce_search_ctrl #(.PARTITIONBITS(4), .MAX_INFLIGHT(MAXI), .JOBIDBITS(8)) dut (
    .clk(clk), .rst(rst),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_id_i(job_id_i), .job_rounds_i(job_rounds_i), .abort_i(abort_i),
    .proc_valid_o(proc_valid_o), .proc_newblock_o(proc_newblock_o),
    .dec_valid_i(dec_valid_i), .dec_success_i(dec_success_i), .dec_nonce_i(dec_nonce_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_status_o(res_status_o), .res_nonce_o(res_nonce_o),
    .res_job_id_o(res_job_id_o), .busy_o(busy_o)
  );

  typedef struct { logic [1:0] st; logic [31:0] nonce; logic [7:0] id; } res_t;
  res_t exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_res(input logic [1:0] st, input logic [31:0] nonce, input logic [7:0] id);
    exp_q.push_back('{st: st, nonce: nonce, id: id});
  endtask

  // Scoreboard monitor: pops an expectation whenever a result record appears.
  res_t cur;
  bit   presenting = 0;
  always @(posedge clk) begin
    #1;
    if (res_valid_o === 1'b1) begin
      if (!presenting) begin
        presenting = 1;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
          cur = '{st: 2'd3, nonce: 32'h0, id: 8'h0};
        end else begin
          cur = exp_q.pop_front();
          check("res_status", res_status_o, cur.st);
          check("res_nonce",  res_nonce_o,  cur.nonce);
          check("res_job_id", res_job_id_o, cur.id);
        end
      end else begin
        check("res_stable", {res_status_o, res_nonce_o, res_job_id_o}, {cur.st, cur.nonce, cur.id});
      end
    end else begin
      presenting = 0;
    end
  end

  // Decoder model and per-job issue statistics.
  int          cycle = 0;
  int          dly = 3;
  bit          hold = 0, manual = 0;
  int          pend[$];
  int          issues, retires, nb, first_issue, late, stop_cycle;
  int          succ_a, succ_b;
  logic [31:0] nonce_a, nonce_b;
  bit          arm_abort = 0, auto_abort = 0;
  int          infl_bad = 0, nb_bad = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle++;
    if (proc_newblock_o && !proc_valid_o) nb_bad++;
    if (proc_valid_o) begin
      if (issues - retires >= MAXI) infl_bad++;
      if (first_issue < 0) first_issue = cycle;
      if (cycle > stop_cycle) late++;
      if (proc_newblock_o) nb++;
      issues++;
      pend.push_back(cycle + dly);
    end
    if (auto_abort) begin
      abort_i = 1'b0;
      auto_abort = 0;
    end
    if (!manual) begin
      dec_valid_i = 1'b0;
      dec_success_i = 1'b0;
      dec_nonce_i = '0;
      if (!hold && pend.size() > 0 && pend[0] <= cycle) begin
        void'(pend.pop_front());
        retires++;
        dec_valid_i = 1'b1;
        dec_nonce_i = 32'hDEAD_0000 + 32'(retires);
        if (retires == succ_a) begin
          dec_success_i = 1'b1;
          dec_nonce_i = nonce_a;
          if (stop_cycle == BIG) stop_cycle = cycle;
          if (arm_abort) begin
            abort_i = 1'b1;
            auto_abort = 1;
            arm_abort = 0;
          end
        end else if (retires == succ_b) begin
          dec_success_i = 1'b1;
          dec_nonce_i = nonce_b;
        end
      end
    end
  endtask

  task automatic start_job(input logic [7:0] id, input logic [27:0] rounds);
    int acc;
    issues = 0; retires = 0; nb = 0; first_issue = -1; late = 0;
    stop_cycle = BIG; succ_a = 0; succ_b = 0;
    pend.delete();
    check("job_ready_idle", job_ready_o, 1);
    job_id_i = id;
    job_rounds_i = rounds;
    job_valid_i = 1'b1;
    acc = cycle;
    cyc();
    job_valid_i = 1'b0;
    check("first_issue_latency", first_issue, acc + 1);
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n = 0;
    while (busy_o && n < maxc) begin
      cyc();
      n++;
    end
    check({name, "_done"}, busy_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, bad;
    // Reset state
    @(posedge clk);
    #1;
    check("rst_job_ready", job_ready_o, 1);
    check("rst_proc_valid", proc_valid_o, 0);
    check("rst_newblock", proc_newblock_o, 0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_fields", {res_status_o, res_nonce_o, res_job_id_o}, 0);
    rst = 1'b1;
    cyc();

    // 1: five rounds, no hit
    expect_res(2'd1, 32'h0, 8'h12);
    start_job(8'h12, 28'd5);
    wait_done("t1", 200);
    check("t1_issues", issues, 5);
    check("t1_newblock", nb, 1);

    // 2: hit on 7th retire, second hit on 8th ignored
    expect_res(2'd0, 32'h0000_0071, 8'h34);
    start_job(8'h34, 28'd100);
    succ_a = 7; nonce_a = 32'h0000_0071;
    succ_b = 8; nonce_b = 32'h0000_0099;
    wait_done("t2", 500);
    check("t2_late_issue", late, 0);
    check("t2_hit_seen", stop_cycle != BIG, 1);

    // 3: silent decoder forces stall at MAX_INFLIGHT
    hold = 1;
    expect_res(2'd1, 32'h0, 8'h56);
    start_job(8'h56, 28'd40);
    repeat (40) cyc();
    check("t3_issues_stalled", issues, MAXI);
    hold = 0; dly = 1;
    wait_done("t3", 500);
    check("t3_issues_total", issues, 40);
    dly = 3;

    // 4a: abort into a full-space job
    expect_res(2'd2, 32'h0, 8'h78);
    start_job(8'h78, 28'd0);
    repeat (9) cyc();
    abort_i = 1'b1;
    stop_cycle = cycle;
    cyc();
    abort_i = 1'b0;
    wait_done("t4a", 200);
    check("t4a_late_issue", late, 0);

    // 4b: abort and success in the same cycle
    expect_res(2'd0, 32'hABCD_0123, 8'h79);
    start_job(8'h79, 28'd0);
    repeat (9) cyc();
    succ_a = retires + 1; nonce_a = 32'hABCD_0123;
    arm_abort = 1;
    wait_done("t4b", 200);
    check("t4b_late_issue", late, 0);

    // 5: downstream back-pressure
    res_ready_i = 1'b0;
    expect_res(2'd1, 32'h0, 8'h9A);
    start_job(8'h9A, 28'd2);
    n = 0;
    while (!res_valid_o && n < 100) begin
      cyc();
      n++;
    end
    check("t5_res_valid", res_valid_o, 1);
    bad = 0;
    repeat (20) begin
      cyc();
      if (job_ready_o !== 1'b0 || res_valid_o !== 1'b1) bad++;
    end
    check("t5_hold_bad_cycles", bad, 0);
    res_ready_i = 1'b1;
    cyc();
    check("t5_job_ready_after", job_ready_o, 1);
    check("t5_res_valid_after", res_valid_o, 0);
    check("t5_busy_after", busy_o, 0);

    // 6: async reset mid-run with 5 in flight, stale retires afterwards
    hold = 1;
    start_job(8'hBC, 28'd0);
    n = 0;
    while (issues < 6 && n < 50) begin
      cyc();
      n++;
    end
    check("t6_issues_before_rst", issues, 6);
    rst = 1'b0;
    #1;
    check("t6_rst_job_ready", job_ready_o, 1);
    check("t6_rst_proc_valid", proc_valid_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_res_valid", res_valid_o, 0);
    manual = 1;
    dec_valid_i = 1'b0; dec_success_i = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    dec_valid_i = 1'b1; dec_success_i = 1'b1; dec_nonce_i = 32'h5555_AAAA;
    bad = 0;
    repeat (4) begin
      cyc();
      if (res_valid_o !== 1'b0 || busy_o !== 1'b0 || job_ready_o !== 1'b1) bad++;
    end
    check("t6_stale_retire_bad", bad, 0);
    dec_valid_i = 1'b0; dec_success_i = 1'b0;
    manual = 0; hold = 0;
    cyc();
    expect_res(2'd1, 32'h0, 8'hDE);
    start_job(8'hDE, 28'd3);
    wait_done("t6", 200);
    check("t6_issues", issues, 3);

    repeat (3) cyc();
    check("inflight_limit_bad", infl_bad, 0);
    check("newblock_without_valid", nb_bad, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
